// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter for the shared data-memory/peripheral bus port (CPU data port m0, UART loader m1).
// One command per cycle, read data routed back to its owner one cycle later, locked bursts with a hold limit.
module mem_bus_arbiter #(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int RR       = 1,
  parameter int MAX_HOLD = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic          m0_lock,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic          m1_lock,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_M0   = 2'd1,
    OWN_M1   = 2'd2
  } owner_e;

  owner_e     r_lockOwner;
  owner_e     w_lockOwnerNext;
  owner_e     w_liveOwner;
  owner_e     w_grantId;
  logic       r_last;
  logic [7:0] r_holdCnt;
  logic [7:0] w_holdCntNext;
  logic       r_rdPend;
  logic       r_rdTag;
  logic       w_gnt0;
  logic       w_gnt1;
  logic       w_holdAtMax;
  logic       w_ownerReq;
  logic       w_otherReq;
  logic       w_gntLock;

  // Grant selection; outputs stay quiet while reset is asserted.
  always_comb begin
    w_gnt0      = 1'b0;
    w_gnt1      = 1'b0;
    w_holdAtMax = (r_holdCnt >= HOLD_MAX);
    if (rst_n) begin
      if (r_lockOwner == OWN_M0 && m0_req && (!w_holdAtMax || !m1_req)) begin
        w_gnt0 = 1'b1;
      end else if (r_lockOwner == OWN_M1 && m1_req && (!w_holdAtMax || !m0_req)) begin
        w_gnt1 = 1'b1;
      end else if (r_lockOwner == OWN_M0 && m0_req) begin
        w_gnt1 = 1'b1;
      end else if (r_lockOwner == OWN_M1 && m1_req) begin
        w_gnt0 = 1'b1;
      end else if (m0_req && !m1_req) begin
        w_gnt0 = 1'b1;
      end else if (m1_req && !m0_req) begin
        w_gnt1 = 1'b1;
      end else if (m0_req && m1_req) begin
        if (RR != 0 && !r_last) begin
          w_gnt1 = 1'b1;
        end else begin
          w_gnt0 = 1'b1;
        end
      end
    end
  end

  // Lock ownership and hold counter; a lock whose owner stops requesting is dropped first.
  always_comb begin
    w_ownerReq      = (r_lockOwner == OWN_M0) ? m0_req : (r_lockOwner == OWN_M1) ? m1_req : 1'b0;
    w_otherReq      = (r_lockOwner == OWN_M0) ? m1_req : m0_req;
    w_liveOwner     = w_ownerReq ? r_lockOwner : OWN_NONE;
    w_grantId       = w_gnt0 ? OWN_M0 : (w_gnt1 ? OWN_M1 : OWN_NONE);
    w_gntLock       = w_gnt0 ? m0_lock : (w_gnt1 ? m1_lock : 1'b0);
    w_lockOwnerNext = w_liveOwner;
    w_holdCntNext   = r_holdCnt;
    if (w_grantId != OWN_NONE && (w_liveOwner == OWN_NONE || w_liveOwner == w_grantId)) begin
      w_lockOwnerNext = w_gntLock ? w_grantId : OWN_NONE;
    end
    if (w_lockOwnerNext == OWN_NONE || w_lockOwnerNext != r_lockOwner) begin
      w_holdCntNext = 8'd0;
    end else if (w_grantId == r_lockOwner) begin
      if (w_otherReq && r_holdCnt < HOLD_MAX) begin
        w_holdCntNext = r_holdCnt + 8'd1;
      end
    end else begin
      w_holdCntNext = 8'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lockOwner <= OWN_NONE;
      r_holdCnt   <= 8'd0;
      r_last      <= 1'b1;
      r_rdPend    <= 1'b0;
      r_rdTag     <= 1'b0;
    end else begin
      r_lockOwner <= w_lockOwnerNext;
      r_holdCnt   <= w_holdCntNext;
      if (w_gnt0 || w_gnt1) begin
        r_last <= w_gnt1;
      end
      r_rdPend <= (w_gnt0 && !m0_we) || (w_gnt1 && !m1_we);
      r_rdTag  <= w_gnt1;
    end
  end

  assign m0_gnt    = w_gnt0;
  assign m1_gnt    = w_gnt1;
  assign mem_en    = w_gnt0 | w_gnt1;
  assign mem_we    = w_gnt0 ? m0_we    : (w_gnt1 ? m1_we    : 1'b0);
  assign mem_addr  = w_gnt0 ? m0_addr  : (w_gnt1 ? m1_addr  : '0);
  assign mem_wdata = w_gnt0 ? m0_wdata : (w_gnt1 ? m1_wdata : '0);

  assign m0_rvalid = r_rdPend & ~r_rdTag;
  assign m1_rvalid = r_rdPend & r_rdTag;
  assign m0_rdata  = m0_rvalid ? mem_rdata : '0;
  assign m1_rdata  = m1_rvalid ? mem_rdata : '0;
  assign busy      = (r_lockOwner != OWN_NONE);

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
Two-master arbiter sharing the single data-memory/peripheral bus port between the CPU data port (m0) and the UART boot/DMA loader (m1). Issues at most one memory command per cycle, returns read data to the owning master one cycle later, and supports short locked bursts with a hold limit. Sits between the masters and the data memory plus peripheral decode.

Parameters:
AW, 32, address width
DW, 32, data width
RR, 1, 1 = round-robin; 0 = fixed priority with m0 highest
MAX_HOLD, 16, maximum consecutive grants to a locked owner while the other master waits (2..255)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
m0_req  in  1  m0 command request
m0_we  in  1  m0 write enable (0 = read)
m0_lock  in  1  m0 asks to keep ownership after this command
m0_addr  in  AW  m0 address
m0_wdata  in  DW  m0 write data
m0_gnt  out  1  m0 command accepted this cycle
m0_rvalid  out  1  m0 read data valid
m0_rdata  out  DW  m0 read data
m1_req, m1_we, m1_lock, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata  same as m0, for m1
mem_en  out  1  memory command strobe
mem_we  out  1  memory write enable
mem_addr  out  AW  memory address
mem_wdata  out  DW  memory write data
mem_rdata  in  DW  memory read data, valid the cycle after a read command
busy  out  1  a lock is currently held

Behaviour:
- Reset (async, rst_n low): owner = none, lock_owner = none, last = m1 (so m0 wins the first RR tie), hold_cnt = 0, rd_pend = 0. All outputs 0; mem_* and m*_rdata drive 0.
- Grant is combinational within the cycle: exactly one of m0_gnt/m1_gnt is high when at least one req is high; both are low otherwise. Grant is only asserted together with the corresponding req.
- Selection order: (1) lock_owner requesting and hold_cnt < MAX_HOLD -> lock_owner; (2) only one requesting -> that one; (3) both requesting: RR=1 -> the master not equal to last; RR=0 -> m0.
- Hold limit: if lock_owner has hold_cnt == MAX_HOLD and the other master requests, the other master gets exactly one grant, then the lock resumes with hold_cnt reset to 0. If the other master is not requesting, lock_owner keeps the grant and hold_cnt saturates.
- Lock release: lock_owner clears when its granted command has lock = 0, or on a cycle where lock_owner has req = 0. A granted command with lock = 1 sets or keeps lock_owner = that master; hold_cnt increments on each granted cycle of lock_owner while the other master requests, and resets to 0 on lock acquire or release.
- busy = (lock_owner != none), registered.
- Memory command: mem_en = any gnt; mem_we/addr/wdata are muxed from the granted master; all zero when no grant.
- Read return: on a granted read, rd_pend = 1 and rd_tag = granted master, registered. Next cycle m{tag}_rvalid = 1 and m{tag}_rdata = mem_rdata; the other master's rdata = 0. Writes produce no rvalid. Back-to-back reads from alternating masters each return in order, one per cycle.
- last updates to the granted master on every grant, including locked grants.
- Simultaneous events: a read grant in cycle N and an rvalid for cycle N-1 coexist without loss. A lock request from the non-owner while the other master holds the lock is ignored until the lock releases.
- Reset mid-operation: a pending rvalid is dropped, the lock is cleared, and there is no memory command on the cycle reset deasserts unless req is present.

Test Plan:
- Single m0 read of addr 0x40000010, mem_rdata = 0xDEADBEEF -> m0_gnt and mem_en in cycle N with mem_we = 0; m0_rvalid = 1, m0_rdata = 0xDEADBEEF in N+1; m1_rvalid = 0.
- Both masters request continuously with RR=1 -> grants alternate m0,m1,m0,m1 from reset; with RR=0 -> m0 every cycle and m1 never granted.
- m1 locked burst of 4 writes (lock = 1,1,1,0) while m0 requests -> m1 granted 4 consecutive cycles, busy high for 3 cycles, m0 granted in the 5th.
- m1 holds lock indefinitely with MAX_HOLD = 2 and m0 requesting -> pattern m1,m1,m0,m1,m1,m0; hold_cnt returns to 0 after each m0 grant.
- Alternating reads m0(addr A), m1(addr B) with mem_rdata 0x11 then 0x22 -> m0_rdata = 0x11 in N+1, m1_rdata = 0x22 in N+2, with no cross-delivery.
- Assert rst_n low the cycle after an m0 read grant -> m0_rvalid stays 0, busy = 0, all outputs 0 during reset.
